// File: rtl/er_dma_irq_gate.sv
// rtl/er_dma_irq_gate.sv - holds off DMA grants and IRQ delivery while the CPU runs the ER
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      synchronous, active-high reset
//   pc         current program counter
//   ER_min     first address of ER (legal entry point)
//   ER_max     last address of ER (inclusive)
//   dma_req    DMA master bus request (level)
//   dma_grant  registered bus grant to the DMA master
//   irq_in     raw interrupt request (level)
//   irq_out    registered interrupt request forwarded to the core
//   exec       1 = last/ongoing ER run was clean, 0 = tainted or no run
//   timeout    one-cycle pulse when the deferral limit forces grants through
module er_dma_irq_gate #(
    parameter int unsigned          CNT_W     = 16,
    parameter logic [CNT_W-1:0]     MAX_DEFER = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic [15:0] ER_min,
    input  logic [15:0] ER_max,
    input  logic        dma_req,
    output logic        dma_grant,
    input  logic        irq_in,
    output logic        irq_out,
    output logic        exec,
    output logic        timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEFER_LAST = MAX_DEFER - CNT_ONE;

    typedef enum logic [1:0] {
        OUTSIDE = 2'd0,
        INSIDE  = 2'd1,
        DIRTY   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             irq_pend;
    logic             in_er;
    logic             defer;
    logic             defer_last;
    logic             hold;

    // An inverted window (ER_min > ER_max) can never satisfy both bounds.
    assign in_er      = (pc >= ER_min) && (pc <= ER_max);
    assign defer      = dma_req || irq_in || irq_pend;
    assign defer_last = defer && (cnt == DEFER_LAST);

    always_comb begin
        state_next = state;
        case (state)
            OUTSIDE: begin
                if (in_er) begin
                    // A grant already out at entry cannot be revoked, so the run is tainted.
                    state_next = ((pc == ER_min) && !dma_grant) ? INSIDE : DIRTY;
                end
            end
            INSIDE: begin
                // Leaving ER takes priority over a same-cycle deferral timeout.
                if (!in_er) begin
                    state_next = OUTSIDE;
                end else if (defer_last) begin
                    state_next = DIRTY;
                end
            end
            DIRTY: begin
                if (!in_er) begin
                    state_next = OUTSIDE;
                end
            end
            default: state_next = OUTSIDE;
        endcase
    end

    // Holding follows the next state so requests are blocked from the entry edge on.
    assign hold = (state_next == INSIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= OUTSIDE;
            exec      <= 1'b0;
            dma_grant <= 1'b0;
            irq_out   <= 1'b0;
            timeout   <= 1'b0;
            irq_pend  <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            dma_grant <= dma_req && !hold;
            irq_out   <= (irq_in || irq_pend) && !hold;
            // Pending IRQ is consumed on the same edge that forwards it.
            irq_pend  <= hold && (irq_pend || irq_in);
            timeout   <= (state == INSIDE) && (state_next == DIRTY);

            if ((state == OUTSIDE) && (state_next == INSIDE)) begin
                exec <= 1'b1;
            end else if (state_next == DIRTY && state != DIRTY) begin
                exec <= 1'b0;
            end

            if ((state == OUTSIDE) && (state_next == INSIDE)) begin
                cnt <= '0;
            end else if ((state == INSIDE) && defer && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_er_dma_irq_gate.sv
// tb/tb_er_dma_irq_gate.sv - directed and randomized checks of er_dma_irq_gate against a run model
module tb_er_dma_irq_gate;

    localparam int MAXD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] er_min;
    logic [15:0] er_max;
    logic        dma_req;
    logic        irq_in;
    logic        dma_grant;
    logic        irq_out;
    logic        exec;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is "open" while the CPU is in ER after an entry;
    // it is clean if it began at ER_min with no grant outstanding and has not timed out.
    bit m_in_run, m_clean, m_exec, m_grant, m_irq, m_to, m_pend;
    int m_waited;

    er_dma_irq_gate #(
        .CNT_W     (16),
        .MAX_DEFER (16'(MAXD))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .ER_min    (er_min),
        .ER_max    (er_max),
        .dma_req   (dma_req),
        .dma_grant (dma_grant),
        .irq_in    (irq_in),
        .irq_out   (irq_out),
        .exec      (exec),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit in_er, hold, want;
        bit n_run, n_clean, n_exec, n_to;
        if (reset) begin
            m_in_run = 0; m_clean = 0; m_exec = 0; m_grant = 0;
            m_irq = 0; m_to = 0; m_pend = 0; m_waited = 0;
            return;
        end
        in_er   = (int'(pc) >= int'(er_min)) && (int'(pc) <= int'(er_max));
        want    = dma_req || irq_in || m_pend;
        n_run   = m_in_run;
        n_clean = m_clean;
        n_exec  = m_exec;
        n_to    = 0;
        if (!m_in_run) begin
            if (in_er) begin
                n_run   = 1;
                n_clean = (pc == er_min) && !m_grant;
                n_exec  = n_clean;
                if (n_clean) m_waited = 0;
            end
        end else if (!in_er) begin
            n_run = 0;
        end else if (m_clean && want) begin
            if (m_waited >= MAXD - 1) begin
                n_clean = 0;
                n_exec  = 0;
                n_to    = 1;
            end else begin
                m_waited++;
            end
        end
        hold     = n_run && n_clean;
        m_grant  = dma_req && !hold;
        m_irq    = (irq_in || m_pend) && !hold;
        m_pend   = hold && (m_pend || irq_in);
        m_in_run = n_run;
        m_clean  = n_clean;
        m_exec   = n_exec;
        m_to     = n_to;
    endtask

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [15:0] p, input logic d, input logic i);
        pc      = p;
        dma_req = d;
        irq_in  = i;
        @(posedge clk);
        model_step();
        #1;
        check("dma_grant", dma_grant, m_grant);
        check("irq_out",   irq_out,   m_irq);
        check("exec",      exec,      m_exec);
        check("timeout",   timeout,   m_to);
    endtask

    initial begin
        logic [15:0] rp;
        int sel;
        reset  = 1'b1;
        er_min = 16'hE000;
        er_max = 16'hE0FF;
        m_in_run = 0; m_clean = 0; m_exec = 0; m_grant = 0;
        m_irq = 0; m_to = 0; m_pend = 0; m_waited = 0;
        cyc(16'h4000, 1'b1, 1'b1);
        cyc(16'h4000, 1'b1, 1'b1);
        check("reset_exec", exec, 1'b0);
        check("reset_grant", dma_grant, 1'b0);
        reset = 1'b0;

        // 1: clean walk through ER
        for (int k = 0; k <= 16; k++) begin
            cyc(16'hE000 + 16'(k), 1'b0, 1'b0);
            if (k == 0) check("s1_exec_entry", exec, 1'b1);
        end
        cyc(16'h4000, 1'b0, 1'b0);
        check("s1_exec_after", exec, 1'b1);

        // 2: DMA deferred until exit
        cyc(16'hE000, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc(16'hE000 + 16'(k), 1'b1, 1'b0);
            check("s2_grant_held", dma_grant, 1'b0);
        end
        cyc(16'h4000, 1'b1, 1'b0);
        check("s2_grant_exit", dma_grant, 1'b1);
        check("s2_exec", exec, 1'b1);
        cyc(16'h4000, 1'b0, 1'b0);

        // 3: IRQ pulse deferred until exit
        cyc(16'hE000, 1'b0, 1'b0);
        cyc(16'hE001, 1'b0, 1'b1);
        for (int k = 2; k <= 6; k++) cyc(16'hE000 + 16'(k), 1'b0, 1'b0);
        cyc(16'h4000, 1'b0, 1'b0);
        check("s3_irq_exit", irq_out, 1'b1);
        cyc(16'h4000, 1'b0, 1'b0);
        check("s3_irq_clear", irq_out, 1'b0);

        // 4: DMA held past the deferral limit
        cyc(16'hE000, 1'b0, 1'b0);
        for (int k = 1; k <= MAXD; k++) cyc(16'hE010, 1'b1, 1'b0);
        check("s4_timeout", timeout, 1'b1);
        check("s4_exec", exec, 1'b0);
        check("s4_grant", dma_grant, 1'b1);
        cyc(16'hE011, 1'b1, 1'b0);
        check("s4_timeout_pulse", timeout, 1'b0);
        cyc(16'h4000, 1'b0, 1'b0);

        // 5: entry away from ER_min
        cyc(16'hE004, 1'b0, 1'b0);
        check("s5_exec_dirty", exec, 1'b0);
        cyc(16'hE005, 1'b1, 1'b0);
        check("s5_grant_free", dma_grant, 1'b1);
        cyc(16'h4000, 1'b0, 1'b0);
        cyc(16'hE000, 1'b0, 1'b0);
        check("s5_exec_clean", exec, 1'b1);

        // 6: grant outstanding at entry, then reset mid-run
        cyc(16'h4000, 1'b1, 1'b0);
        cyc(16'hE000, 1'b1, 1'b0);
        check("s6_exec_tainted", exec, 1'b0);
        cyc(16'h4000, 1'b0, 1'b0);
        cyc(16'hE000, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(16'hE001, 1'b1, 1'b1);
        check("s6_reset_exec", exec, 1'b0);
        check("s6_reset_grant", dma_grant, 1'b0);
        check("s6_reset_irq", irq_out, 1'b0);
        reset = 1'b0;
        cyc(16'hE002, 1'b0, 1'b0);
        check("s6_release_dirty", exec, 1'b0);
        cyc(16'h4000, 1'b0, 1'b0);

        // Exit and timeout on the same edge: exit wins
        cyc(16'hE000, 1'b0, 1'b0);
        for (int k = 1; k < MAXD; k++) cyc(16'hE001, 1'b1, 1'b0);
        cyc(16'h4000, 1'b1, 1'b0);
        check("exit_wins_timeout", timeout, 1'b0);
        check("exit_wins_exec", exec, 1'b1);

        // Inverted window never counts as in ER
        er_min = 16'hE100;
        er_max = 16'hE000;
        cyc(16'hE100, 1'b1, 1'b0);
        cyc(16'hE000, 1'b1, 1'b1);
        check("inverted_grant", dma_grant, 1'b1);
        check("inverted_irq", irq_out, 1'b1);
        er_min = 16'hE000;
        er_max = 16'hE0FF;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    rp = 16'hE000;
                2:       rp = 16'hE0FF;
                3:       rp = 16'hE100;
                4:       rp = 16'hDFFF;
                5, 6:    rp = 16'h4000 + 16'($urandom_range(0, 255));
                default: rp = 16'hE000 + 16'($urandom_range(0, 255));
            endcase
            // Sticky pc so runs last long enough to reach the deferral limit
            if (n > 0 && $urandom_range(0, 3) != 0) rp = pc;
            reset = ($urandom_range(0, 199) == 0);
            cyc(rp, 1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 10));
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
